id_issue_stage: RTL and testbench
=================================

Name: id_issue_stage

Overview:
- Decode/issue stage feeding the execute stage. Accepts fetched instructions over a valid/ready handshake and decodes the RV64 add-class subset into inst_type, op1 and op2.
- Reads register operands and enforces RAW/WAW interlocks with a 32-entry busy scoreboard.
- Holds one registered issue slot toward execute; writeback releases scoreboard entries.

Parameters:
- XLEN, 64, operand/pc width
- TYPE_W, 8, inst_type width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- if_valid  in  1  fetch offers instruction
- if_ready  out  1  stage accepts instruction this cycle
- if_inst  in  32  instruction word
- if_pc  in  XLEN  instruction address
- rs1_addr  out  5  regfile read addr 1 (= if_inst[19:15])
- rs1_data  in  XLEN  regfile read data 1 (combinational read)
- rs2_addr  out  5  regfile read addr 2 (= if_inst[24:20])
- rs2_data  in  XLEN  regfile read data 2
- ex_valid  out  1  issue slot holds instruction
- ex_ready  in  1  execute consumes slot
- inst_type  out  TYPE_W  operation code
- op1  out  XLEN  operand 1
- op2  out  XLEN  operand 2
- rd_addr  out  5  destination register
- rd_wen  out  1  destination written
- illegal  out  1  slot holds undecodable instruction
- wb_valid  in  1  writeback retires a register write
- wb_addr  in  5  register retired
- flush  in  1  kill issue slot (redirect)

Behaviour:
- Reset (rst=0, async): ex_valid=0, inst_type=INST_NONE, op1=op2=0, rd_addr=0, rd_wen=0, illegal=0, all busy bits=0. if_ready=0 while in reset.
- Slot FSM, 2 states:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on ex_ready && !accept, or on flush.
  - FULL -> FULL on ex_ready && accept (back-to-back; full throughput).
- hazard = (busy[rs1] && rs1 used) || (busy[rs2] && rs2 used) || (busy[rd] && rd_wen). x0 is never busy and never set busy.
- if_ready = !flush && !hazard && (slot EMPTY || ex_ready).
- accept = if_valid && if_ready.
- Latency: accept in cycle N -> ex_valid=1 with captured operands in cycle N+1. Outputs are registered and held stable while ex_valid && !ex_ready.
- Decode (all legal ops map to INST_ADD):
  - ADD (op 0110011, f3 000, f7 0): op1=rs1, op2=rs2
  - ADDI (0010011, f3 000): op1=rs1, op2=sext(I-imm)
  - LUI (0110111): op1=0, op2=sext(imm[31:12]<<12)
  - AUIPC (0010111): op1=pc, op2=sext(imm[31:12]<<12)
  - Any other encoding: inst_type=INST_NONE, rd_wen=0, illegal=1, op1=op2=0.
- rd_wen=0 whenever rd=0.
- Scoreboard:
  - On accept with rd_wen: set busy[rd].
  - On wb_valid: clear busy[wb_addr].
  - Same index set and clear in one cycle: set wins.
  - The hazard check uses registered busy bits (no bypass). A clear in cycle N unblocks issue in N+1.
- Flush: ex_valid->0 next cycle. If the killed slot had rd_wen, its busy bit is cleared. No accept in a flush cycle. Instructions already in execute/writeback still report through wb_valid.
- Reset mid-operation discards the slot and the scoreboard immediately.

Optional Feature:
- Macro ID_PERF_EN.
- When defined: adds outputs perf_issue (32) and perf_stall (32).
  - perf_issue counts accepts.
  - perf_stall counts cycles with if_valid && hazard.
  - Both wrap modulo 2^32 and reset to 0.
- When undefined: no such ports and no counters.

Decomposition:
- Shared package/defines: INST_NONE=8'h00, INST_ADD=8'h01, opcode constants, REG_BUS width, ZERO_WORD.
- Sub-module id_scoreboard: busy vector, set/clear/flush-clear, hazard query for three indices.

Test Plan:
- ADDI x1,x0,5 (0x00500093) then ex_ready=1: ex_valid next cycle; inst_type=01, op1=0, op2=5, rd=1, rd_wen=1, busy[1]=1.
- ADD x2,x1,x1 right after it: if_ready=0 until wb_valid/wb_addr=1; issues the cycle after that clear.
- LUI x3,0x80000 at pc 0x80000000: op2=0xFFFFFFFF80000000. AUIPC x4,1 at pc 0x80000004: op1=0x80000004, op2=0x1000.
- ex_ready held 0 for 3 cycles with a FULL slot and a new if_valid: outputs stable, if_ready=0. ex_ready=1 and a new accept in the same cycle: next instruction in the slot, no bubble.
- Illegal 0xFFFFFFFF: illegal=1, inst_type=00, rd_wen=0, no busy bit set. addi x0,x0,0: rd_wen=0, never stalls.
- flush with the slot holding ADDI x5: ex_valid=0 next cycle and busy[5] cleared. Async rst=0 mid-stall clears all outputs within the same cycle.

Source files
------------

// File: rtl/id_issue_stage_pkg.sv
// Shared constants, types and the instruction-class decoder for the ID/issue stage.
// No ports; imported by id_issue_stage and id_scoreboard.
package id_issue_stage_pkg;

  localparam int unsigned REG_BUS  = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [7:0]  INST_NONE = 8'h00;
  localparam logic [7:0]  INST_ADD  = 8'h01;

  localparam logic [63:0] ZERO_WORD = 64'h0;

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;

  typedef enum logic {S_EMPTY, S_FULL} slot_state_t;

  typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_PC} op1_sel_t;
  typedef enum logic [1:0] {OP2_ZERO, OP2_RS2, OP2_IMM_I, OP2_IMM_U} op2_sel_t;

  typedef struct packed {
    logic     legal;
    logic     rs1_used;
    logic     rs2_used;
    op1_sel_t op1_sel;
    op2_sel_t op2_sel;
  } dec_ctl_t;

  // Classify an instruction word into operand sources and register usage.
  function automatic dec_ctl_t decode_ctl(input logic [31:0] inst);
    dec_ctl_t c;
    c.legal    = 1'b0;
    c.rs1_used = 1'b0;
    c.rs2_used = 1'b0;
    c.op1_sel  = OP1_ZERO;
    c.op2_sel  = OP2_ZERO;
    case (inst[6:0])
      OPC_OP: begin
        if (inst[14:12] == 3'b000 && inst[31:25] == 7'b0000000) begin
          c.legal    = 1'b1;
          c.rs1_used = 1'b1;
          c.rs2_used = 1'b1;
          c.op1_sel  = OP1_RS1;
          c.op2_sel  = OP2_RS2;
        end
      end
      OPC_OP_IMM: begin
        if (inst[14:12] == 3'b000) begin
          c.legal    = 1'b1;
          c.rs1_used = 1'b1;
          c.op1_sel  = OP1_RS1;
          c.op2_sel  = OP2_IMM_I;
        end
      end
      OPC_LUI: begin
        c.legal   = 1'b1;
        c.op2_sel = OP2_IMM_U;
      end
      OPC_AUIPC: begin
        c.legal   = 1'b1;
        c.op1_sel = OP1_PC;
        c.op2_sel = OP2_IMM_U;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Register busy scoreboard: one bit per architectural register.
// Ports: set_en/set_addr (issue of a writer), clr_en/clr_addr (writeback),
// kill_en/kill_addr (flushed slot), three query indices with use flags,
// hazard_c (combinational, from registered busy bits only).
module id_scoreboard
  import id_issue_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en,
  input  logic [REG_BUS-1:0] set_addr,
  input  logic               clr_en,
  input  logic [REG_BUS-1:0] clr_addr,
  input  logic               kill_en,
  input  logic [REG_BUS-1:0] kill_addr,
  input  logic [REG_BUS-1:0] rs1_addr,
  input  logic               rs1_used,
  input  logic [REG_BUS-1:0] rs2_addr,
  input  logic               rs2_used,
  input  logic [REG_BUS-1:0] rd_addr,
  input  logic               rd_used,
  output logic               hazard_c
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clears first, then set, so a same-index set survives; x0 is pinned idle.
  always_comb begin
    busy_d = busy_q;
    if (clr_en)  busy_d[clr_addr]  = 1'b0;
    if (kill_en) busy_d[kill_addr] = 1'b0;
    if (set_en)  busy_d[set_addr]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign hazard_c = (rs1_used && busy_q[rs1_addr]) ||
                    (rs2_used && busy_q[rs2_addr]) ||
                    (rd_used  && busy_q[rd_addr]);

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: decodes the RV64 add-class subset, interlocks on a busy
// scoreboard and holds one registered issue slot toward execute.
// Ports: if_* fetch handshake, rs*_addr/rs*_data regfile read, ex_* issue slot
// (inst_type, op1, op2, rd_addr, rd_wen, illegal), wb_* scoreboard release,
// flush kills the slot. rst is asynchronous active-low.
// Optional: define ID_PERF_EN to add perf_issue/perf_stall counters.
module id_issue_stage
  import id_issue_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned TYPE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [31:0]        if_inst,
  input  logic [XLEN-1:0]    if_pc,
  output logic [REG_BUS-1:0] rs1_addr,
  input  logic [XLEN-1:0]    rs1_data,
  output logic [REG_BUS-1:0] rs2_addr,
  input  logic [XLEN-1:0]    rs2_data,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [TYPE_W-1:0]  inst_type,
  output logic [XLEN-1:0]    op1,
  output logic [XLEN-1:0]    op2,
  output logic [REG_BUS-1:0] rd_addr,
  output logic               rd_wen,
  output logic               illegal,
  input  logic               wb_valid,
  input  logic [REG_BUS-1:0] wb_addr,
  input  logic               flush
`ifdef ID_PERF_EN
  ,
  output logic [31:0]        perf_issue,
  output logic [31:0]        perf_stall
`endif
);

  slot_state_t        state_q, state_d;
  dec_ctl_t           ctl;
  logic [REG_BUS-1:0] rd_c;
  logic               rd_wen_c;
  logic [XLEN-1:0]    imm_i, imm_u;
  logic [XLEN-1:0]    op1_c, op2_c;
  logic               hazard_c;
  logic               accept_c;
  logic               kill_c;

  // Decode of the offered instruction
  assign ctl      = decode_ctl(if_inst);
  assign rs1_addr = if_inst[19:15];
  assign rs2_addr = if_inst[24:20];
  assign rd_c     = if_inst[11:7];
  assign rd_wen_c = ctl.legal && (rd_c != '0);
  assign imm_i    = {{(XLEN-12){if_inst[31]}}, if_inst[31:20]};
  assign imm_u    = {{(XLEN-32){if_inst[31]}}, if_inst[31:12], 12'h000};

  always_comb begin
    op1_c = '0;
    op2_c = '0;
    case (ctl.op1_sel)
      OP1_RS1: op1_c = rs1_data;
      OP1_PC:  op1_c = if_pc;
      default: op1_c = '0;
    endcase
    case (ctl.op2_sel)
      OP2_RS2:   op2_c = rs2_data;
      OP2_IMM_I: op2_c = imm_i;
      OP2_IMM_U: op2_c = imm_u;
      default:   op2_c = '0;
    endcase
  end

  // Handshake; rst gates if_ready so nothing is taken while held in reset
  assign if_ready = rst && !flush && !hazard_c && (state_q == S_EMPTY || ex_ready);
  assign accept_c = if_valid && if_ready;
  assign kill_c   = flush && (state_q == S_FULL) && rd_wen;

  id_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept_c && rd_wen_c),
    .set_addr (rd_c),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .kill_en  (kill_c),
    .kill_addr(rd_addr),
    .rs1_addr (rs1_addr),
    .rs1_used (ctl.rs1_used),
    .rs2_addr (rs2_addr),
    .rs2_used (ctl.rs2_used),
    .rd_addr  (rd_c),
    .rd_used  (rd_wen_c),
    .hazard_c (hazard_c)
  );

  // Issue slot state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_EMPTY;
    else      state_q <= state_d;
  end

  // Issue slot next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept_c) state_d = S_FULL;
      S_FULL: begin
        if (flush)                      state_d = S_EMPTY;
        else if (ex_ready && !accept_c) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  assign ex_valid = (state_q == S_FULL);

  // Slot payload: loaded only on accept, otherwise held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_type <= TYPE_W'(INST_NONE);
      op1       <= XLEN'(ZERO_WORD);
      op2       <= XLEN'(ZERO_WORD);
      rd_addr   <= '0;
      rd_wen    <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept_c) begin
      inst_type <= ctl.legal ? TYPE_W'(INST_ADD) : TYPE_W'(INST_NONE);
      op1       <= op1_c;
      op2       <= op2_c;
      rd_addr   <= rd_c;
      rd_wen    <= rd_wen_c;
      illegal   <= !ctl.legal;
    end
  end

`ifdef ID_PERF_EN
  // Free-running event counters, wrap modulo 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (accept_c)              perf_issue <= perf_issue + 32'd1;
      if (if_valid && hazard_c)  perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_issue_stage.sv
// Self-checking bench for id_issue_stage: decode vector table, directed
// interlock/stall/flush/reset sequences, and randomized traffic against a
// behavioural model.
module tb_id_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_inst = '0;
  logic [63:0] if_pc = '0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [63:0] rs1_data = '0, rs2_data = '0;
  logic        ex_valid;
  logic        ex_ready = 1'b1;
  logic [7:0]  inst_type;
  logic [63:0] op1, op2;
  logic [4:0]  rd_addr;
  logic        rd_wen, illegal;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic        flush = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_issue_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .rs1_addr(rs1_addr), .rs1_data(rs1_data),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .inst_type(inst_type), .op1(op1), .op2(op2),
    .rd_addr(rd_addr), .rd_wen(rd_wen), .illegal(illegal),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          legal;
    bit          u1, u2;
    logic [63:0] o1, o2;
    logic [4:0]  rd;
    bit          wen;
  } ref_dec_t;

  function automatic ref_dec_t ref_decode(input logic [31:0] i, input logic [63:0] pc,
                                          input logic [63:0] r1, input logic [63:0] r2);
    ref_dec_t d;
    int imm;
    logic [6:0] opc;
    opc = i[6:0];
    d.legal = 0; d.u1 = 0; d.u2 = 0; d.o1 = 0; d.o2 = 0; d.rd = i[11:7]; d.wen = 0;
    if (opc == 7'h33 && i[14:12] == 3'd0 && i[31:25] == 7'd0) begin
      d.legal = 1; d.u1 = 1; d.u2 = 1; d.o1 = r1; d.o2 = r2;
    end else if (opc == 7'h13 && i[14:12] == 3'd0) begin
      imm = int'(i[31:20]);
      if (imm >= 2048) imm -= 4096;
      d.legal = 1; d.u1 = 1; d.o1 = r1; d.o2 = 64'(longint'(imm));
    end else if (opc == 7'h37 || opc == 7'h17) begin
      imm = int'(i[31:12]);
      if (imm >= 524288) imm -= 1048576;
      d.legal = 1; d.o2 = 64'(longint'(imm) * 64'sd4096);
      d.o1 = (opc == 7'h17) ? pc : 64'd0;
    end
    d.wen = d.legal && (d.rd != 5'd0);
    return d;
  endfunction

  bit       m_busy [32];
  bit       m_valid;
  ref_dec_t m_slot;

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc, r1, r2;
    logic [7:0]  ty;
    logic [63:0] o1, o2;
    logic [4:0]  rd;
    bit          wen, ill;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [31:0] rand_inst();
    logic [4:0]  r1, r2, rd;
    logic [31:0] w;
    r1 = 5'($urandom_range(0, 3));
    r2 = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0: w = {7'd0, r2, r1, 3'd0, rd, 7'h33};
      1: w = {12'($urandom), r1, 3'd0, rd, 7'h13};
      2: w = {20'($urandom), rd, 7'h37};
      3: w = {20'($urandom), rd, 7'h17};
      4: w = $urandom;
      default: w = {7'h20, r2, r1, 3'd0, rd, 7'h33};
    endcase
    return w;
  endfunction

  initial begin
    ref_dec_t d;
    bit       haz, rdy, acc;
    logic [31:0] w;

    vecs[0] = '{32'h00500093, 64'h0, 64'h0, 64'h9, 8'h01, 64'h0, 64'h5, 5'd1, 1, 0};
    vecs[1] = '{32'h800001B7, 64'h80000000, 64'h7, 64'h9, 8'h01, 64'h0, 64'hFFFFFFFF80000000, 5'd3, 1, 0};
    vecs[2] = '{32'h00001217, 64'h80000004, 64'h7, 64'h9, 8'h01, 64'h80000004, 64'h1000, 5'd4, 1, 0};
    vecs[3] = '{32'hFFFFFFFF, 64'h40, 64'h7, 64'h9, 8'h00, 64'h0, 64'h0, 5'd31, 0, 1};
    vecs[4] = '{32'h00000013, 64'h44, 64'h0, 64'h0, 8'h01, 64'h0, 64'h0, 5'd0, 0, 0};
    vecs[5] = '{32'h00838333, 64'h48, 64'h1111, 64'h2222, 8'h01, 64'h1111, 64'h2222, 5'd6, 1, 0};
    vecs[6] = '{32'hFFF50493, 64'h4C, 64'h10, 64'h0, 8'h01, 64'h10, 64'hFFFFFFFFFFFFFFFF, 5'd9, 1, 0};
    vecs[7] = '{32'h40838333, 64'h50, 64'h1, 64'h2, 8'h00, 64'h0, 64'h0, 5'd6, 0, 1};
    vecs[8] = '{32'h00839333, 64'h54, 64'h1, 64'h2, 8'h00, 64'h0, 64'h0, 5'd6, 0, 1};

    // Reset state, with fetch already offering an instruction
    if_valid = 1; if_inst = 32'h00500093;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_inst_type", inst_type, 8'h00);
    chk("rst_op1", op1, 0);
    chk("rst_op2", op2, 0);
    chk("rst_rd", rd_addr, 0);
    chk("rst_rd_wen", rd_wen, 0);
    chk("rst_illegal", illegal, 0);
    @(negedge clk);
    rst = 1; if_valid = 0;

    // Decode table: issue each, check the slot, release its rd
    foreach (vecs[i]) begin
      @(negedge clk);
      if_inst = vecs[i].inst; if_pc = vecs[i].pc;
      rs1_data = vecs[i].r1; rs2_data = vecs[i].r2;
      if_valid = 1; ex_ready = 1;
      #1;
      w = vecs[i].inst;
      chk($sformatf("v%0d_if_ready", i), if_ready, 1);
      chk($sformatf("v%0d_rs1_addr", i), rs1_addr, w[19:15]);
      chk($sformatf("v%0d_rs2_addr", i), rs2_addr, w[24:20]);
      @(negedge clk);
      if_valid = 0;
      chk($sformatf("v%0d_ex_valid", i), ex_valid, 1);
      chk($sformatf("v%0d_type", i), inst_type, vecs[i].ty);
      chk($sformatf("v%0d_op1", i), op1, vecs[i].o1);
      chk($sformatf("v%0d_op2", i), op2, vecs[i].o2);
      chk($sformatf("v%0d_rd", i), rd_addr, vecs[i].rd);
      chk($sformatf("v%0d_rd_wen", i), rd_wen, vecs[i].wen);
      chk($sformatf("v%0d_illegal", i), illegal, vecs[i].ill);
      if (vecs[i].wen) begin
        wb_valid = 1; wb_addr = vecs[i].rd;
        @(negedge clk);
        wb_valid = 0;
      end
    end

    // RAW interlock: ADD x2,x1,x1 behind ADDI x1 waits for writeback of x1
    @(negedge clk);
    if_inst = 32'h00500093; rs1_data = 0; if_valid = 1; ex_ready = 1;
    #1 chk("raw_first_ready", if_ready, 1);
    @(negedge clk);
    if_inst = 32'h00108133; rs1_data = 64'h55; rs2_data = 64'h55;
    #1;
    chk("raw_first_valid", ex_valid, 1);
    chk("raw_first_rd", rd_addr, 1);
    chk("raw_stall0", if_ready, 0);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("raw_stall%0d", k), if_ready, 0);
    end
    @(negedge clk);
    wb_valid = 1; wb_addr = 1;
    #1 chk("raw_no_bypass", if_ready, 0);
    @(negedge clk);
    wb_valid = 0;
    #1 chk("raw_unblock", if_ready, 1);
    @(negedge clk);
    if_valid = 0;
    chk("raw_issue_valid", ex_valid, 1);
    chk("raw_issue_rd", rd_addr, 2);
    chk("raw_issue_op1", op1, 64'h55);
    wb_valid = 1; wb_addr = 2;
    @(negedge clk);
    wb_valid = 0;

    // Backpressure hold, then back-to-back replacement with no bubble
    @(negedge clk);
    if_inst = 32'h00700293; rs1_data = 0; if_valid = 1; ex_ready = 0;
    #1 chk("bp_first_ready", if_ready, 1);
    @(negedge clk);
    if_inst = 32'h800001B7; if_pc = 64'h80000000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_hold_valid%0d", k), ex_valid, 1);
      chk($sformatf("bp_hold_op2_%0d", k), op2, 64'h7);
      chk($sformatf("bp_hold_rd%0d", k), rd_addr, 5);
      chk($sformatf("bp_hold_ready%0d", k), if_ready, 0);
      @(negedge clk);
    end
    ex_ready = 1;
    #1 chk("b2b_ready", if_ready, 1);
    @(negedge clk);
    if_valid = 0;
    chk("b2b_valid", ex_valid, 1);
    chk("b2b_rd", rd_addr, 3);
    chk("b2b_op2", op2, 64'hFFFFFFFF80000000);
    @(negedge clk);
    chk("b2b_drain", ex_valid, 0);
    wb_valid = 1; wb_addr = 5;
    @(negedge clk);
    wb_addr = 3;
    @(negedge clk);
    wb_valid = 0;

    // Flush kills the slot and frees its destination
    @(negedge clk);
    if_inst = 32'h00700293; rs1_data = 0; if_valid = 1; ex_ready = 0;
    @(negedge clk);
    if_inst = 32'h00028333; flush = 1;
    #1;
    chk("flush_valid_before", ex_valid, 1);
    chk("flush_blocks_accept", if_ready, 0);
    @(negedge clk);
    flush = 0;
    #1;
    chk("flush_kill", ex_valid, 0);
    chk("flush_clr_busy", if_ready, 1);
    @(negedge clk);
    if_valid = 0; ex_ready = 1;
    chk("flush_next_valid", ex_valid, 1);
    chk("flush_next_rd", rd_addr, 6);
    @(negedge clk);
    wb_valid = 1; wb_addr = 6;
    @(negedge clk);
    wb_valid = 0;

    // Asynchronous reset in the middle of a stall
    @(negedge clk);
    if_inst = 32'h00500093; rs1_data = 0; if_valid = 1; ex_ready = 0;
    @(negedge clk);
    if_inst = 32'h00108133;
    #1 chk("arst_stalled", if_ready, 0);
    #2 rst = 0;
    #1;
    chk("arst_ex_valid", ex_valid, 0);
    chk("arst_if_ready", if_ready, 0);
    chk("arst_op2", op2, 0);
    chk("arst_rd", rd_addr, 0);
    chk("arst_rd_wen", rd_wen, 0);
    chk("arst_type", inst_type, 0);
    @(negedge clk);
    rst = 1;
    #1 chk("arst_busy_gone", if_ready, 1);
    @(negedge clk);
    if_valid = 0; ex_ready = 1;

    // Randomized traffic against the model, from a fresh reset
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    foreach (m_busy[i]) m_busy[i] = 0;
    m_valid = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      if_inst  = rand_inst();
      if_pc    = {$urandom, $urandom};
      rs1_data = {$urandom, $urandom};
      rs2_data = {$urandom, $urandom};
      if_valid = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 11) == 0);
      ex_ready = flush ? 1'b0 : ($urandom_range(0, 9) < 7);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_addr  = 5'($urandom_range(0, 3));
      #1;
      d   = ref_decode(if_inst, if_pc, rs1_data, rs2_data);
      haz = (d.u1 && m_busy[if_inst[19:15]]) || (d.u2 && m_busy[if_inst[24:20]]) ||
            (d.wen && m_busy[d.rd]);
      rdy = !flush && !haz && (!m_valid || ex_ready);
      acc = if_valid && rdy;
      chk("rnd_if_ready", if_ready, rdy);
      @(posedge clk);
      if (flush && m_valid && m_slot.wen) m_busy[m_slot.rd] = 0;
      if (wb_valid) m_busy[wb_addr] = 0;
      if (acc && d.wen) m_busy[d.rd] = 1;
      m_busy[0] = 0;
      if (acc) begin
        m_valid = 1; m_slot = d;
      end else if (flush || ex_ready) begin
        m_valid = 0;
      end
      #1;
      chk("rnd_ex_valid", ex_valid, m_valid);
      if (m_valid) begin
        chk("rnd_type", inst_type, m_slot.legal ? 8'h01 : 8'h00);
        chk("rnd_op1", op1, m_slot.o1);
        chk("rnd_op2", op2, m_slot.o2);
        chk("rnd_rd_wen", rd_wen, m_slot.wen);
        chk("rnd_illegal", illegal, !m_slot.legal);
        if (m_slot.wen) chk("rnd_rd", rd_addr, m_slot.rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
